// File: rtl/dm_lsu_if.sv
// rtl/dm_lsu_if.sv - request/response and data-memory signal bundle for dm_lsu
interface dm_lsu_if #(
  parameter int AW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] dm_addr;
  logic          dm_we;
  logic [31:0]   dm_wd;
  logic [31:0]   dm_rd;

  // master: the core plus the data memory; slave: the load/store unit
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
    input  req_ready, resp_valid, resp_err, resp_rdata, dm_addr, dm_we, dm_wd
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rd,
    output req_ready, resp_valid, resp_err, resp_rdata, dm_addr, dm_we, dm_wd
  );
endinterface

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - RV32I load/store initiator for a word-wide data memory
module dm_lsu #(
  parameter int AW = 5
) (
  input  logic     clk,
  input  logic     rst,
  dm_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] widx_q;
  logic [1:0]    lane_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [31:0]   merge_q;
  logic          err_q;

  logic          accept;
  logic          bad_f3;
  logic          misaligned;
  logic          req_err;
  logic [31:0]   byte_sh;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;

  assign accept = bus.req_valid & (state == IDLE);

  // unsigned loads have no store counterpart, so 100/101 are only legal as loads
  always_comb begin
    bad_f3     = 1'b0;
    misaligned = 1'b0;
    case (bus.req_funct3)
      3'b000:         bad_f3 = 1'b0;
      3'b001:         misaligned = bus.req_addr[0];
      3'b010:         misaligned = (bus.req_addr[1:0] != 2'b00);
      3'b100:         bad_f3 = bus.req_we;
      3'b101: begin
        bad_f3     = bus.req_we;
        misaligned = bus.req_addr[0];
      end
      default:        bad_f3 = 1'b1;
    endcase
    req_err = bad_f3 | misaligned;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                                    state_nxt = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010) state_nxt = WRITE;
          else                                            state_nxt = READ;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_sh  = bus.dm_rd >> {lane_q, 3'b000};
    half_sel = lane_q[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'h0, byte_sh[7:0]};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = bus.dm_rd;
    endcase
  end

  // sb/sh: splice the new lane into the word just read, written back in WRITE
  always_comb begin
    merge_val = bus.dm_rd;
    if (f3_q[0]) merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else         merge_val[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      widx_q  <= '0;
      lane_q  <= 2'b00;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        widx_q  <= bus.req_addr[AW+1:2];
        lane_q  <= bus.req_addr[1:0];
        f3_q    <= bus.req_funct3;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rdata_q <= 32'h0;
      end
      if (state == READ) begin
        if (we_q) merge_q <= merge_val;
        else      rdata_q <= load_val;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.dm_addr    = widx_q;
  assign bus.dm_we      = (state == WRITE) & rst;
  assign bus.dm_wd      = (state == WRITE) ? (f3_q[1] ? wdata_q : merge_q) : 32'h0;

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - scoreboard bench for dm_lsu with a behavioural data memory
module tb_dm_lsu;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dm_lsu_if #(.AW(AW)) bus();
  dm_lsu #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        init_we  = 1'b0;
  logic [4:0]  init_idx = 5'd0;
  logic [31:0] init_val = 32'h0;

  assign bus.dm_rd = mem[bus.dm_addr];
  always @(posedge clk) begin
    if (init_we)         mem[init_idx]    <= init_val;
    else if (bus.dm_we)  mem[bus.dm_addr] <= bus.dm_wd;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {int cyc; logic err; logic [31:0] rdata;} resp_t;
  typedef struct {int cyc; logic [4:0] addr; logic [31:0] wd;} wr_t;
  resp_t rq[$];
  wr_t   wq[$];
  logic [31:0] last_rdata = 32'h0;
  logic        last_err   = 1'b0;

  initial begin
    resp_t r;
    wr_t   w;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.resp_valid) begin
          checks++;
          if (rq.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: cyc=%0d got err=%0b rdata=%08h, required no response", cyc, bus.resp_err, bus.resp_rdata);
          end else begin
            r = rq.pop_front();
            if (cyc !== r.cyc || bus.resp_err !== r.err || bus.resp_rdata !== r.rdata) begin
              errors++;
              $display("FAIL resp: got cyc=%0d err=%0b rdata=%08h, required cyc=%0d err=%0b rdata=%08h", cyc, bus.resp_err, bus.resp_rdata, r.cyc, r.err, r.rdata);
            end
          end
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
        end
        if (bus.dm_we) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected: cyc=%0d got addr=%0d wd=%08h, required no write", cyc, bus.dm_addr, bus.dm_wd);
          end else begin
            w = wq.pop_front();
            if (cyc !== w.cyc || bus.dm_addr !== w.addr || bus.dm_wd !== w.wd) begin
              errors++;
              $display("FAIL write: got cyc=%0d addr=%0d wd=%08h, required cyc=%0d addr=%0d wd=%08h", cyc, bus.dm_addr, bus.dm_wd, w.cyc, w.addr, w.wd);
            end
          end
        end else begin
          checks++;
          if (bus.dm_wd !== 32'h0) begin
            errors++;
            $display("FAIL dm_wd_idle: got %08h, required 00000000", bus.dm_wd);
          end
        end
      end else begin
        checks++;
        if (bus.dm_we !== 1'b0 || bus.resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL in_reset: got dm_we=%0b resp_valid=%0b, required 0 0", bus.dm_we, bus.resp_valid);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit dropped, output int t);
    int          n;
    int          sh;
    logic        bad;
    logic [4:0]  wi;
    logic [31:0] w, v, mask;
    resp_t       r;
    wr_t         x;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL accept_timeout: got req_ready=%0b, required 1 within 20 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      t = cyc;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    t = cyc - 1;
    if (dropped) return;
    wi  = addr[AW+1:2];
    w   = ref_mem[wi];
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5)) ||
          ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) || (f3 == 3'd2 && addr[1:0] != 2'b00);
    r.err = 1'b0;
    r.rdata = 32'h0;
    if (bad) begin
      r.cyc = t + 1;
      r.err = 1'b1;
    end else if (!we) begin
      r.cyc = t + 2;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = (w >> (8 * addr[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = (w >> (16 * addr[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      r.rdata = v;
    end else if (f3 == 3'd2) begin
      r.cyc = t + 2;
      x.cyc = t + 1; x.addr = wi; x.wd = wd;
      wq.push_back(x);
      ref_mem[wi] = wd;
    end else begin
      r.cyc = t + 3;
      mask = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
      sh   = (f3 == 3'd0) ? 8 * addr[1:0] : 16 * addr[1];
      v    = (w & ~(mask << sh)) | ((wd & mask) << sh);
      x.cyc = t + 2; x.addr = wi; x.wd = v;
      wq.push_back(x);
      ref_mem[wi] = v;
    end
    rq.push_back(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses %0d writes pending, required 0", rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      v = (i == 3) ? 32'h8899AABB : $urandom;
      init_we = 1'b1; init_idx = i[4:0]; init_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    init_we = 1'b0;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.dm_we, bus.dm_addr, bus.dm_wd, bus.resp_err, bus.resp_rdata} !==
        {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%0b rv=%0b we=%0b addr=%0d wd=%08h err=%0b rd=%08h, required 1 0 0 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.dm_we, bus.dm_addr, bus.dm_wd, bus.resp_err, bus.resp_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd2};
    logic [31:0] ads [5] = '{32'h0D, 32'h0F, 32'h0E, 32'h0C, 32'h0C};
    logic [31:0] exs [5] = '{32'hFFFFFFAA, 32'h00000088, 32'h00008899, 32'hFFFFAABB, 32'h8899AABB};
    int t;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3s[i], ads[i], 32'h0, 1'b0, t);
      @(negedge clk);
      checks++;
      if (bus.dm_addr !== 5'd3) begin
        errors++;
        $display("FAIL load_dm_addr[%0d]: got %0d, required 3", i, bus.dm_addr);
      end
      wait_idle();
      checks++;
      if (last_rdata !== exs[i] || last_err !== 1'b0) begin
        errors++;
        $display("FAIL load_value[%0d]: got %08h err=%0b, required %08h err=0", i, last_rdata, last_err, exs[i]);
      end
    end
  endtask

  task automatic test_sb();
    int t;
    issue(1'b1, 3'd0, 32'h0E, 32'h123456CC, 1'b0, t);
    wait_idle();
    checks++;
    if (mem[3] !== 32'h88CCAABB) begin
      errors++;
      $display("FAIL sb_mem: got %08h, required 88ccaabb", mem[3]);
    end
    issue(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0, t);
    wait_idle();
    checks++;
    if (last_rdata !== 32'h88CCAABB) begin
      errors++;
      $display("FAIL sb_readback: got %08h, required 88ccaabb", last_rdata);
    end
  endtask

  task automatic test_sw();
    int t;
    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, t);
    issue(1'b1, 3'd2, 32'h80, 32'h13579BDF, 1'b0, t);
    wait_idle();
    checks++;
    if (mem[4] !== 32'hDEADBEEF || mem[0] !== 32'h13579BDF) begin
      errors++;
      $display("FAIL sw_mem: got w4=%08h w0=%08h, required deadbeef 13579bdf", mem[4], mem[0]);
    end
  endtask

  task automatic test_errors();
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
    logic [31:0] ads [4] = '{32'h0E, 32'h01, 32'h00, 32'h00};
    int t;
    for (int i = 0; i < 4; i++) begin
      issue(wes[i], f3s[i], ads[i], 32'hFFFFFFFF, 1'b0, t);
      wait_idle();
      checks++;
      if (last_err !== 1'b1 || last_rdata !== 32'h0) begin
        errors++;
        $display("FAIL error_resp[%0d]: got err=%0b rdata=%08h, required err=1 rdata=00000000", i, last_err, last_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    issue(1'b1, 3'd1, 32'h1A, 32'h0000BEEF, 1'b1, t);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %0b, required 1", bus.req_ready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (mem[6] !== ref_mem[6]) begin
      errors++;
      $display("FAIL reset_mid_mem: got %08h, required %08h", mem[6], ref_mem[6]);
    end
  endtask

  task automatic test_back_to_back();
    logic        wes [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [5] = '{3'd2, 3'd0, 3'd2, 3'd1, 3'd4};
    logic [31:0] ads [5] = '{32'h0C, 32'h05, 32'h08, 32'h03, 32'h07};
    int          gap [4] = '{3, 4, 3, 2};
    int t, tp;
    for (int i = 0; i < 5; i++) begin
      issue(wes[i], f3s[i], ads[i], $urandom, 1'b0, t);
      if (i > 0) begin
        checks++;
        if (t - tp !== gap[i-1]) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d, required %0d", i, t - tp, gap[i-1]);
        end
      end
      tp = t;
    end
    wait_idle();
  endtask

  task automatic test_random();
    int t;
    int bad = 0;
    for (int i = 0; i < 60; i++)
      issue($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom & 32'hFFF, $urandom, 1'b0, t);
    wait_idle();
    for (int i = 0; i < 32; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_mem: got %0d differing words, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sb();
    test_sw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
